// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/execute/writeback states and
// drives datapath enables and mux selects from the state, IR fields and the ALU zero flag.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        Adr_src,
  output logic        Mem_Write,
  output logic        IR_write,
  output logic [1:0]  Result_src,
  output logic [1:0]  ALU_src_A,
  output logic [1:0]  ALU_src_B,
  output logic [2:0]  ALU_control,
  output logic [1:0]  Imm_src,
  output logic        Reg_write,
  output logic        instr_retired,
  output logic        illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [2:0] alu_dec_s;
  logic       taken_s;
  logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s, retired_s, illegal_s;
  logic       unused_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign unused_s = ^{instr[31], instr[29:15], instr[11:7]};
  assign taken_s  = ((funct3_s == 3'b000) &&  zero) ||
                    ((funct3_s == 3'b001) && !zero) ||
                    ((funct3_s == 3'b100) && !zero);

  // State register: the only flop in the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operation for R-type and I-type ALU instructions (sub only when R-type with bit 30).
  always_comb begin
    alu_dec_s = ALU_ADD;
    case (funct3_s)
      3'b000:  begin
        if (instr[5] && instr[30]) alu_dec_s = ALU_SUB;
        else                       alu_dec_s = ALU_ADD;
      end
      3'b010:  alu_dec_s = ALU_SLT;
      3'b110:  alu_dec_s = ALU_OR;
      3'b111:  alu_dec_s = ALU_AND;
      default: alu_dec_s = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    Imm_src = 2'b00;
    case (opcode_s)
      OP_STORE:  Imm_src = 2'b01;
      OP_BRANCH: Imm_src = 2'b10;
      OP_JAL:    Imm_src = 2'b11;
      default:   Imm_src = 2'b00;
    endcase
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d     = state_q;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    retired_s   = 1'b0;
    illegal_s   = 1'b0;
    Adr_src     = 1'b0;
    Result_src  = 2'b00;
    ALU_src_A   = 2'b00;
    ALU_src_B   = 2'b00;
    ALU_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALU_src_B  = 2'b10;
        Result_src = 2'b10;
        pc_write_s = mem_ready;
        ir_write_s = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b01;
        case (opcode_s)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_s = ILLEGAL_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        ALU_src_A = 2'b10;
        ALU_src_B = 2'b01;
        if (instr[5]) state_d = S_MEMWRITE;
        else          state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        Adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        Result_src  = 2'b01;
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        Adr_src     = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          retired_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        ALU_src_A   = 2'b10;
        ALU_control = alu_dec_s;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALU_src_A   = 2'b10;
        ALU_src_B   = 2'b01;
        ALU_control = alu_dec_s;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src_A = 2'b10;
        case (funct3_s)
          3'b000, 3'b001: ALU_control = ALU_SUB;
          3'b100:         ALU_control = ALU_SLT;
          default:        ALU_control = ALU_ADD;
        endcase
        pc_write_s = taken_s;
        retired_s  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // ALUOut already holds the target from DECODE; ALU computes the link value.
        ALU_src_A  = 2'b01;
        ALU_src_B  = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are suppressed while reset is held so an aborted access has no side effect.
  assign PC_write      = rst_n & pc_write_s;
  assign IR_write      = rst_n & ir_write_s;
  assign Mem_Write     = rst_n & mem_write_s;
  assign Reg_write     = rst_n & reg_write_s;
  assign instr_retired = rst_n & retired_s;
  assign illegal_instr = rst_n & illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step plans built from the opcode rules,
// compared against the DUT every cycle, plus directed literal checks.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [31:0] instr;
  logic        PC_write, Adr_src, Mem_Write, IR_write, Reg_write, instr_retired, illegal_instr;
  logic [1:0]  Result_src, ALU_src_A, ALU_src_B, Imm_src;
  logic [2:0]  ALU_control;
  logic [15:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .PC_write(PC_write), .Adr_src(Adr_src), .Mem_Write(Mem_Write), .IR_write(IR_write),
    .Result_src(Result_src), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B),
    .ALU_control(ALU_control), .Imm_src(Imm_src), .Reg_write(Reg_write),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  // {PC_write, Adr_src, Mem_Write, IR_write, Result_src, A, B, ALU, Reg_write, retired, illegal}
  assign dut_vec = {PC_write, Adr_src, Mem_Write, IR_write, Result_src, ALU_src_A, ALU_src_B,
                    ALU_control, Reg_write, instr_retired, illegal_instr};

  localparam int B_PCW = 15, B_ADR = 14, B_MW = 13, B_IRW = 12, B_RW = 2, B_RET = 1, B_ILL = 0;

  typedef struct {
    logic [15:0] base;  // outputs regardless of mem_ready
    logic [15:0] rdy;   // outputs additionally high when mem_ready=1
    bit          wt;    // step repeats until mem_ready
    bit          br;    // PC_write is the branch decision
    bit          ld;    // new instruction visible on instr from this step
  } step_t;

  step_t       plan[$];
  logic [31:0] plan_instr;
  logic [31:0] forced;
  bit          use_forced = 1'b0;
  logic [15:0] hist[$];
  logic [1:0]  hist_imm[$];
  int          tests = 0, fails = 0;

  function automatic logic [15:0] mk(input logic [3:0] strb, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [2:0] tail);
    return {strb, rs, a, b, alu, tail};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ins);
    case (ins[14:12])
      3'b000:  return (ins[5] && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] br_alu(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b001) return 3'b001;
    else if (f3 == 3'b100)            return 3'b101;
    else                              return 3'b000;
  endfunction

  function automatic logic taken(input logic [31:0] ins, input logic z);
    case (ins[14:12])
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 6);
    case (k)
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: r[6:0] = 7'b0110011;
      3: r[6:0] = 7'b0010011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b1101111;
      default: begin
        for (int t = 0; t < 50 && is_legal(r[6:0]); t++) r[6:0] = 7'($urandom());
        if (is_legal(r[6:0])) r[6:0] = 7'h7F;
      end
    endcase
    return r;
  endfunction

  task automatic push(input logic [15:0] base, input logic [15:0] rdy, input bit wt,
                      input bit br, input bit ld);
    step_t s;
    s.base = base; s.rdy = rdy; s.wt = wt; s.br = br; s.ld = ld;
    plan.push_back(s);
  endtask

  // Expected step sequence for one instruction, from the per-class state lists.
  task automatic build(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    plan_instr = ins;
    push(mk(4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000),
         mk(4'b1001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000), 1'b1, 1'b0, 1'b0);
    push(mk(4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, {2'b00, !is_legal(op)}),
         16'h0000, 1'b0, 1'b0, 1'b1);
    if (op == 7'b0000011) begin
      push(mk(4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000), 16'h0000, 1'b0, 1'b0, 1'b0);
      push(mk(4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000), 16'h0000, 1'b1, 1'b0, 1'b0);
      push(mk(4'b0000, 2'b01, 2'b00, 2'b00, 3'b000, 3'b110), 16'h0000, 1'b0, 1'b0, 1'b0);
    end else if (op == 7'b0100011) begin
      push(mk(4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000), 16'h0000, 1'b0, 1'b0, 1'b0);
      push(mk(4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000),
           mk(4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010), 1'b1, 1'b0, 1'b0);
    end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1101111) begin
      if (op == 7'b0110011)
        push(mk(4'b0000, 2'b00, 2'b10, 2'b00, alu_of(ins), 3'b000), 16'h0000, 1'b0, 1'b0, 1'b0);
      else if (op == 7'b0010011)
        push(mk(4'b0000, 2'b00, 2'b10, 2'b01, alu_of(ins), 3'b000), 16'h0000, 1'b0, 1'b0, 1'b0);
      else
        push(mk(4'b1000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000), 16'h0000, 1'b0, 1'b0, 1'b0);
      push(mk(4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b110), 16'h0000, 1'b0, 1'b0, 1'b0);
    end else if (op == 7'b1100011) begin
      push(mk(4'b0000, 2'b00, 2'b10, 2'b00, br_alu(ins[14:12]), 3'b010),
           16'h0000, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, compare against the plan, advance at the rising edge.
  task automatic cycle(input int rdy, input int zv);
    logic [15:0] exp;
    if (plan.size() == 0) begin
      if (use_forced) build(forced);
      else            build(rand_instr());
      use_forced = 1'b0;
    end
    @(negedge clk);
    mem_ready = (rdy < 0) ? ($urandom_range(0, 3) != 0) : rdy[0];
    zero      = (zv < 0) ? 1'($urandom_range(0, 1)) : zv[0];
    if (plan[0].ld) instr = plan_instr;
    #2;
    exp = plan[0].base | (mem_ready ? plan[0].rdy : 16'h0000);
    if (plan[0].br) exp[B_PCW] = taken(plan_instr, zero);
    chk("ctl", 32'(dut_vec), 32'(exp));
    case (instr[6:0])
      7'b0000011, 7'b0010011: chk("imm", 32'(Imm_src), 32'd0);
      7'b0100011:             chk("imm", 32'(Imm_src), 32'd1);
      7'b1100011:             chk("imm", 32'(Imm_src), 32'd2);
      7'b1101111:             chk("imm", 32'(Imm_src), 32'd3);
      default: ;
    endcase
    hist.push_back(dut_vec);
    hist_imm.push_back(Imm_src);
    if (!plan[0].wt || mem_ready) void'(plan.pop_front());
  endtask

  task automatic dir(input logic [31:0] ins, input int n, input int zv);
    hist.delete();
    hist_imm.delete();
    forced = ins;
    use_forced = 1'b1;
    for (int i = 0; i < n; i++) cycle(1, zv);
  endtask

  function automatic int col_sum(input int bitpos);
    int s = 0;
    foreach (hist[i]) s += int'(hist[i][bitpos]);
    return s;
  endfunction

  initial begin
    int ninstr, guard;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = 32'h0000_0000;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_strobes", 32'({PC_write, IR_write, Mem_Write, Reg_write, instr_retired, illegal_instr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;

    // lw x1,4(x2): five cycles, single writeback in the last one
    dir(32'h0041_2083, 5, 0);
    chk("lw_rw_last", 32'(hist[4][B_RW]), 32'd1);
    chk("lw_rs_last", 32'(hist[4][11:10]), 32'd1);
    chk("lw_rw_count", 32'(col_sum(B_RW)), 32'd1);
    chk("lw_retired_count", 32'(col_sum(B_RET)), 32'd1);
    chk("lw_latency", 32'(plan.size()), 32'd0);

    // sw with three wait cycles in MEMWRITE
    hist.delete(); hist_imm.delete();
    forced = 32'h0011_2223; use_forced = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 3; i < 7; i++) chk("sw_mw_adr", 32'({hist[i][B_MW], hist[i][B_ADR]}), 32'd3);
    chk("sw_mw_count", 32'(col_sum(B_MW)), 32'd4);
    chk("sw_no_rw", 32'(col_sum(B_RW)), 32'd0);
    chk("sw_latency", 32'(plan.size()), 32'd0);

    dir(32'h0000_0063, 3, 1);
    chk("beq_z1_pcw", 32'(hist[2][B_PCW]), 32'd1);
    dir(32'h0000_0063, 3, 0);
    chk("beq_z0_pcw", 32'(hist[2][B_PCW]), 32'd0);
    dir(32'h0000_1063, 3, 0);
    chk("bne_pcw", 32'(hist[2][B_PCW]), 32'd1);
    chk("bne_alu", 32'(hist[2][5:3]), 32'd1);
    dir(32'h0000_4063, 3, 0);
    chk("blt_pcw", 32'(hist[2][B_PCW]), 32'd1);
    chk("blt_alu", 32'(hist[2][5:3]), 32'd5);

    dir(32'h4020_81B3, 4, -1);
    chk("sub_alu", 32'(hist[2][5:3]), 32'd1);
    dir(32'h0050_8093, 4, -1);
    chk("addi_alu", 32'(hist[2][5:3]), 32'd0);
    chk("addi_srcb", 32'(hist[2][7:6]), 32'd1);
    chk("addi_imm", 32'(hist_imm[2]), 32'd0);

    dir(32'h0080_00EF, 4, -1);
    chk("jal_pcw", 32'(hist[2][B_PCW]), 32'd1);
    chk("jal_ab", 32'(hist[2][9:6]), 32'b0110);
    chk("jal_wb", 32'({hist[3][B_RW], hist[3][11:10]}), 32'b100);
    chk("jal_latency", 32'(plan.size()), 32'd0);

    dir(32'h0000_007F, 2, -1);
    chk("illegal_pulse", 32'(hist[1][B_ILL]), 32'd1);
    chk("illegal_count", 32'(col_sum(B_ILL)), 32'd1);
    chk("illegal_no_ret", 32'(col_sum(B_RET)), 32'd0);

    // reset asserted while waiting in MEMREAD
    hist.delete(); hist_imm.delete();
    forced = 32'h0041_2083; use_forced = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 0);
    cycle(0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk("midreset_strobes", 32'({PC_write, IR_write, Mem_Write, Reg_write, instr_retired, illegal_instr}), 32'd0);
    plan.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    hist.delete(); hist_imm.delete();
    cycle(1, -1);
    chk("post_reset_fetch", 32'(hist[0][B_IRW]), 32'd1);

    // randomized instruction stream with random stalls
    ninstr = 0;
    guard = 0;
    while (ninstr < 400 && guard < 30000) begin
      cycle(-1, -1);
      if (plan.size() == 0) ninstr++;
      guard++;
    end
    chk("random_progress", 32'(ninstr), 32'd400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
